tone_serializer: RTL
====================

TONE_SERIALIZER -- requirements
Module: tone_serializer

Interface
REQ-001 SHALL have parameter DIV_W, default 22: width of tone half-period inputs.
REQ-002 SHALL have parameter FADE_STEP_FRAMES, default 256: frames per volume step when fade is compiled in.
REQ-003 SHALL have port clk, input, 1: single system clock (100 MHz); all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port div_l, input, DIV_W: left tone half-period in clk cycles; 0 means silence.
REQ-006 SHALL have port div_r, input, DIV_W: right tone half-period in clk cycles; 0 means silence.
REQ-007 SHALL have port volume, input, 3: amplitude code 0..7.
REQ-008 SHALL have port mute, input, 1: forces output amplitude to zero.
REQ-009 SHALL have ports audio_mclk, audio_lrck, audio_sck, audio_sdin, outputs, 1 each: I2S DAC pins.

Function
REQ-010 SHALL keep a free-running 9-bit counter cnt, wrapping 511->0; audio_mclk=cnt[1], audio_sck=cnt[3], audio_lrck=cnt[8] (frame = 512 clk, 32 sck slots, slot s=cnt[8:4]).
REQ-011 SHALL drive sdin per slot: slots 1..16 carry left bits 15..0 (MSB first), slots 17..31 carry right bits 15..1, slot 0 carries the right LSB of the previous frame.
REQ-012 SHALL latch the new {left,right} sample pair into the 32-bit shift register on the clk where cnt==15, so it is used from slot 1.
REQ-013 SHALL change audio_sdin only on the clk where cnt[3:0] wraps 15->0 (sck falling edge), registered, no combinational path from inputs.
REQ-014 SHALL, per channel, run a half-period counter: when count >= div-1, clear count and toggle phase; otherwise increment.
REQ-015 SHALL, when div==0, hold count=0 and phase=0 and produce sample 0.
REQ-016 SHALL, when div differs from its registered copy of the previous clk, restart count=0 and phase=0 on that clk.
REQ-017 SHALL compute amp = 0 for effective volume 0, else 16'h0080 << volume (vol 7 -> 16'h4000).
REQ-018 SHALL output sample = +amp when phase=1, two's-complement -amp when phase=0; mute forces amp 0 (immediate form, see REQ-024).
REQ-019 SHALL sample div/volume/mute every clk; only the latch at cnt==15 determines transmitted values.

Reset
REQ-020 SHALL, on reset low, clear cnt, shift register, tone counters, phases, div copies, effective volume; all audio outputs 0.
REQ-021 SHALL, on reset release, start at cnt=0; first nonzero sample appears no earlier than slot 1 of frame 0.
REQ-022 SHALL abort any frame in progress on mid-frame reset without emitting remaining bits.

Configuration
REQ-023 SHALL support macro TONE_MUTE_FADE_EN.
REQ-024 SHALL, without TONE_MUTE_FADE_EN, apply mute and volume changes at the next sample latch.
REQ-025 SHALL, with TONE_MUTE_FADE_EN, step effective volume by one code toward target (0 when muted, else volume) every FADE_STEP_FRAMES frames; reset value 0.

Structure
REQ-026 SHALL place in shared package audio_pkg: frame length 512, slot width 16, latch point 15, mclk/sck/lrck bit indices, base amplitude 16'h0080.
REQ-027 SHALL implement per-channel counter/phase/sample logic in sub-module tone_gen, instantiated twice.
REQ-028 SHALL keep serializer and frame counter in tone_serializer top.

Verification
REQ-029 SHALL verify: reset low 5 clk, release, div=0 -> sdin 0 for 4 frames; mclk period 4, sck 16, lrck 512 clk.
REQ-030 SHALL verify: div_l=1000, volume=3 -> left samples 16'h0400 / 16'hFC00 alternating every 1000 clk; right stays 0.
REQ-031 SHALL verify: bit order, left=16'h0400 latched -> sdin high only in slot 6; right LSB appears in slot 0 of next frame.
REQ-032 SHALL verify: div_l changes 1000->500 mid-period -> phase restarts 0 next clk, next toggle 500 clk later.
REQ-033 SHALL verify: mute asserted, volume=7, macro off -> next latched samples 0; macro on, FADE_STEP_FRAMES=2 -> amplitude 16'h4000,2000,1000,... reaching 0 after 14 frames.
REQ-034 SHALL verify: reset pulsed at cnt=200 -> outputs 0 asynchronously, restart at cnt=0 after release.

Source files
------------

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared constants and types for the I2S tone serializer.
//   - Frame timing: 512 clk per stereo frame, split into 32 slots of 16 clk.
//   - Pin taps into the 9-bit frame counter for MCLK, SCK and LRCK.
//   - Sample types and the volume-code to amplitude mapping.
// No ports (package).
// -----------------------------------------------------------------------------
package audio_pkg;

    // Frame counter geometry
    localparam int CNT_W     = 9;
    localparam int FRAME_LEN = 512;
    localparam int SLOT_W    = 16;
    localparam int SLOT_BITS = 4;          // log2(SLOT_W)

    // Counter value on which the next {left,right} pair is loaded, one clk
    // before slot 1 begins.
    localparam logic [CNT_W-1:0] LATCH_POINT = CNT_W'(15);
    localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_LEN - 1);

    // Output pin taps into the frame counter
    localparam int MCLK_BIT = 1;
    localparam int SCK_BIT  = 3;
    localparam int LRCK_BIT = 8;

    // Sample formatting
    localparam int SAMPLE_W = 16;
    localparam int PAIR_W   = 2 * SAMPLE_W;
    localparam logic [SAMPLE_W-1:0] BASE_AMP = 16'h0080;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } sample_pair_t;

    // Volume code 0 is silence; codes 1..7 give BASE_AMP shifted up by the code.
    function automatic sample_t amp_from_vol(input logic [2:0] vol);
        sample_t amp;
        amp = '0;
        if (vol != 3'd0) begin
            amp = BASE_AMP << vol;
        end
        return amp;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// -----------------------------------------------------------------------------
// tone_gen
// One square-wave tone channel. A half-period counter toggles a phase bit
// every i_div clk cycles; the sample is +amp on phase 1 and -amp (two's
// complement) on phase 0. A zero divider silences the channel, and any change
// of divider restarts the waveform from phase 0.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   i_div     in   half-period in clk cycles, 0 = silence
//   i_amp     in   current amplitude (already volume/mute adjusted)
//   o_sample  out  signed 16-bit sample for this channel
// -----------------------------------------------------------------------------
module tone_gen
    import audio_pkg::*;
#(
    parameter int DIV_W = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] i_div,
    input  sample_t          i_amp,
    output sample_t          o_sample
);

    logic [DIV_W-1:0] r_div_q;     // divider seen on the previous clk
    logic [DIV_W-1:0] r_count;
    logic             r_phase;

    logic             w_div_zero;
    logic             w_div_changed;
    logic             w_period_end;

    assign w_div_zero    = (i_div == '0);
    assign w_div_changed = (i_div != r_div_q);
    // Only meaningful when i_div is nonzero; the zero case is handled first.
    assign w_period_end  = (r_count >= i_div - DIV_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every flop here
    // updates from pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_q <= '0;
            r_count <= '0;
            r_phase <= 1'b0;
        end else begin
            r_div_q <= i_div;
            if (w_div_zero || w_div_changed) begin
                r_count <= '0;
                r_phase <= 1'b0;
            end else if (w_period_end) begin
                r_count <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_count <= r_count + DIV_W'(1);
            end
        end
    end

    // Silence follows the registered divider so the sample path is driven
    // only by flops and the amplitude.
    // NOTE: o_sample gets a default before the branch so no latch is inferred.
    always_comb begin
        o_sample = '0;
        if (r_div_q != '0) begin
            o_sample = r_phase ? i_amp : (~i_amp + SAMPLE_W'(1));
        end
    end

endmodule

// File: rtl/tone_serializer.sv
// -----------------------------------------------------------------------------
// tone_serializer
// Two tone generators feeding a 32-slot I2S-style serializer for a stereo DAC.
// A free-running 9-bit counter defines the frame: MCLK = cnt[1], SCK = cnt[3],
// LRCK = cnt[8]. Slots 1..16 carry the left sample MSB first, slots 17..31 the
// right sample bits 15..1, and slot 0 of the following frame the right LSB.
// SDIN changes only as SCK falls (cnt[3:0] wrapping 15 -> 0).
//
// Build option
//   TONE_MUTE_FADE_EN  when defined, the effective volume walks one code per
//                      FADE_STEP_FRAMES frames toward its target (0 while
//                      muted); otherwise mute/volume apply at the next latch.
//
// Ports
//   clk         in   100 MHz system clock, rising edge
//   reset       in   asynchronous active-low reset
//   div_l       in   left half-period in clk cycles, 0 = silence
//   div_r       in   right half-period in clk cycles, 0 = silence
//   volume      in   amplitude code 0..7
//   mute        in   forces amplitude to zero
//   audio_mclk  out  DAC master clock (clk/4)
//   audio_lrck  out  DAC word select (clk/512)
//   audio_sck   out  DAC bit clock (clk/16)
//   audio_sdin  out  DAC serial data
// -----------------------------------------------------------------------------
module tone_serializer
    import audio_pkg::*;
#(
    parameter int DIV_W            = 22,
    parameter int FADE_STEP_FRAMES = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div_l,
    input  logic [DIV_W-1:0] div_r,
    input  logic [2:0]       volume,
    input  logic             mute,
    output logic             audio_mclk,
    output logic             audio_lrck,
    output logic             audio_sck,
    output logic             audio_sdin
);

    if (FADE_STEP_FRAMES < 1) begin : g_bad_fade_step
        $error("FADE_STEP_FRAMES must be at least 1");
    end

    logic [CNT_W-1:0]  r_cnt;
    logic [PAIR_W-1:0] r_shift;
    logic              r_sdin;
    logic [2:0]        r_eff_vol;

    sample_t           w_amp;
    sample_t           w_left;
    sample_t           w_right;
    sample_pair_t      w_pair;
    logic [PAIR_W-1:0] w_pair_bits;
    logic              w_slot_end;
    logic              w_latch;

    // ------------------------------------------------------------------
    // Tone channels
    // ------------------------------------------------------------------
    assign w_amp = amp_from_vol(r_eff_vol);

    tone_gen #(
        .DIV_W (DIV_W)
    ) u_left (
        .clk      (clk),
        .reset    (reset),
        .i_div    (div_l),
        .i_amp    (w_amp),
        .o_sample (w_left)
    );

    tone_gen #(
        .DIV_W (DIV_W)
    ) u_right (
        .clk      (clk),
        .reset    (reset),
        .i_div    (div_r),
        .i_amp    (w_amp),
        .o_sample (w_right)
    );

    assign w_pair      = '{left: w_left, right: w_right};
    assign w_pair_bits = w_pair;

    // ------------------------------------------------------------------
    // Effective volume
    // ------------------------------------------------------------------
`ifdef TONE_MUTE_FADE_EN
    localparam int FADE_CNT_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam logic [FADE_CNT_W-1:0] FADE_LAST = FADE_CNT_W'(FADE_STEP_FRAMES - 1);

    logic [FADE_CNT_W-1:0] r_fade_cnt;
    logic [2:0]            w_target_vol;
    logic                  w_frame_end;

    assign w_target_vol = mute ? 3'd0 : volume;
    assign w_frame_end  = (r_cnt == FRAME_LAST);

    // One volume code per FADE_STEP_FRAMES frames, always toward the target,
    // so a mute ramps down and an unmute ramps back up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fade_cnt <= '0;
            r_eff_vol  <= 3'd0;
        end else if (w_frame_end) begin
            if (r_fade_cnt == FADE_LAST) begin
                r_fade_cnt <= '0;
                if (r_eff_vol < w_target_vol) begin
                    r_eff_vol <= r_eff_vol + 3'd1;
                end else if (r_eff_vol > w_target_vol) begin
                    r_eff_vol <= r_eff_vol - 3'd1;
                end
            end else begin
                r_fade_cnt <= r_fade_cnt + FADE_CNT_W'(1);
            end
        end
    end
`else
    // Sampled every clk; the serializer only looks at it on the latch clk, so
    // a change takes effect at the next sample latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_eff_vol <= 3'd0;
        end else begin
            r_eff_vol <= mute ? 3'd0 : volume;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Frame counter and serializer
    // ------------------------------------------------------------------
    assign w_slot_end = (r_cnt[SLOT_BITS-1:0] == '1);
    assign w_latch    = (r_cnt == LATCH_POINT);

    // On the latch clk the new pair's MSB goes straight to SDIN for slot 1
    // and the remaining 31 bits park in the shift register. Each later slot
    // boundary shifts one bit out; the 32nd shift (entering slot 0 of the
    // next frame) delivers the right LSB.
    // NOTE: the shift register is ordinary flops, so it is reset along with
    // the counter; that also drops any half-sent frame on a mid-frame reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_sdin  <= 1'b0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_latch) begin
                r_sdin  <= w_pair_bits[PAIR_W-1];
                r_shift <= {w_pair_bits[PAIR_W-2:0], 1'b0};
            end else if (w_slot_end) begin
                r_sdin  <= r_shift[PAIR_W-1];
                r_shift <= {r_shift[PAIR_W-2:0], 1'b0};
            end
        end
    end

    assign audio_mclk = r_cnt[MCLK_BIT];
    assign audio_sck  = r_cnt[SCK_BIT];
    assign audio_lrck = r_cnt[LRCK_BIT];
    assign audio_sdin = r_sdin;

endmodule
